// File: rtl/alu_sequencer.sv
// Shares the ALU2 between NUM_REQ requesters: arbitrate, drive operands, read back, ack.
// Define ALU_SEQ_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
`ifndef ALU_NOP
`define ALU_NOP 0
`endif
`ifndef ALU_SUM_2
`define ALU_SUM_2 1
`endif
`ifndef ALU_SUB_2
`define ALU_SUB_2 2
`endif

module alu_sequencer #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*OP_W-1:0]   i_req_op,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_result,
  output logic [3:0]                o_nzcv,
  output logic                      o_busy,
  output logic [OP_W-1:0]           o_alu_op,
  output logic                      o_bus_drive,
  output logic [2*DATA_W-1:0]       o_bus_opnd,
  output logic                      o_alu_read_data,
  output logic                      o_alu_read_flags,
  input  logic [DATA_W-1:0]         i_bus_result,
  input  logic [3:0]                i_alu_nzcv
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StRead, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     win_idx;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          nzcv_q, nzcv_d;
`ifdef ALU_SEQ_RR_EN
  logic [IdxW-1:0]     ptr_q, ptr_d;
`endif

  // Arbiter: first requester found scanning from the start index.
  always_comb begin : arb
    int unsigned c;
    logic        found;
    win_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_SEQ_RR_EN
      c = (32'(ptr_q) + 1 + i) % NUM_REQ;
`else
      c = i;
`endif
      if (!found && i_req[IdxW'(c)]) begin
        found   = 1'b1;
        win_idx = IdxW'(c);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    grant_d  = grant_q;
    result_d = result_q;
    nzcv_d   = nzcv_q;
`ifdef ALU_SEQ_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          op_d    = i_req_op[win_idx*OP_W +: OP_W];
          a_d     = i_req_a[win_idx*DATA_W +: DATA_W];
          b_d     = i_req_b[win_idx*DATA_W +: DATA_W];
          grant_d = NUM_REQ'(1) << win_idx;
`ifdef ALU_SEQ_RR_EN
          ptr_d   = win_idx;
`endif
          state_d = StExec;
        end
      end
      StExec: state_d = StRead;
      StRead: begin
        result_d = i_bus_result;
        nzcv_d   = i_alu_nzcv;
        state_d  = StDone;
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      op_q     <= OP_W'(`ALU_NOP);
      a_q      <= '0;
      b_q      <= '0;
      grant_q  <= '0;
      result_q <= '0;
      nzcv_q   <= '0;
`ifdef ALU_SEQ_RR_EN
      ptr_q    <= IdxW'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      grant_q  <= grant_d;
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
`ifdef ALU_SEQ_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Drive and read-back strobes are decoded from disjoint states, so they never overlap.
  always_comb begin
    o_grant          = grant_q;
    o_ack            = (state_q == StDone) ? grant_q : '0;
    o_result         = result_q;
    o_nzcv           = nzcv_q;
    o_busy           = (state_q != StIdle);
    o_alu_op         = (state_q == StExec) ? op_q : OP_W'(`ALU_NOP);
    o_bus_drive      = (state_q == StExec);
    o_bus_opnd       = (state_q == StExec) ? {a_q, b_q} : '0;
    o_alu_read_data  = (state_q == StRead);
    o_alu_read_flags = (state_q == StRead);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU2 on the negedge.
`ifndef ALU_NOP
`define ALU_NOP 0
`endif
`ifndef ALU_SUM_2
`define ALU_SUM_2 1
`endif
`ifndef ALU_SUB_2
`define ALU_SUB_2 2
`endif

module tb_alu_sequencer;
  localparam int NR = 4;
  localparam int OW = 5;
  localparam int DW = 8;
  localparam logic [OW-1:0] NOP = OW'(`ALU_NOP);
  localparam logic [OW-1:0] SUM = OW'(`ALU_SUM_2);
  localparam logic [OW-1:0] SUB = OW'(`ALU_SUB_2);

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic [NR-1:0]      i_req;
  logic [NR*OW-1:0]   i_req_op;
  logic [NR*DW-1:0]   i_req_a, i_req_b;
  logic [NR-1:0]      o_grant, o_ack;
  logic [DW-1:0]      o_result;
  logic [3:0]         o_nzcv;
  logic               o_busy;
  logic [OW-1:0]      o_alu_op;
  logic               o_bus_drive;
  logic [2*DW-1:0]    o_bus_opnd;
  logic               o_alu_read_data, o_alu_read_flags;
  logic [DW-1:0]      i_bus_result;
  logic [3:0]         i_alu_nzcv;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  logic [11:0] alu_q = '0;

  alu_sequencer #(.NUM_REQ(NR), .OP_W(OW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_req_op(i_req_op),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .o_grant(o_grant), .o_ack(o_ack),
    .o_result(o_result), .o_nzcv(o_nzcv), .o_busy(o_busy), .o_alu_op(o_alu_op),
    .o_bus_drive(o_bus_drive), .o_bus_opnd(o_bus_opnd),
    .o_alu_read_data(o_alu_read_data), .o_alu_read_flags(o_alu_read_flags),
    .i_bus_result(i_bus_result), .i_alu_nzcv(i_alu_nzcv)
  );

  always #5 i_clk = ~i_clk;

  // ALU2 model: {result, N, Z, C(carry/borrow), V}; NOP keeps the register contents.
  function automatic logic [11:0] alu_f(input logic [11:0] cur, input logic [OW-1:0] op,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       v;
    if (op == SUM) begin
      s = {1'b0, a} + {1'b0, b};
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end else if (op == SUB) begin
      s = {1'b0, a} - {1'b0, b};
      v = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      return cur;
    end
    return {s[7:0], s[7], (s[7:0] == 8'h00), s[8], v};
  endfunction

  always @(negedge i_clk) begin
    if (o_bus_drive) alu_q <= alu_f(alu_q, o_alu_op, o_bus_opnd[15:8], o_bus_opnd[7:0]);
  end

  assign i_bus_result = o_alu_read_data ? alu_q[11:4] : 8'h00;
  assign i_alu_nzcv   = alu_q[3:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      check("bus_contention", 32'(o_bus_drive & o_alu_read_data), 0);
      check("nop_outside_exec", 32'(o_bus_drive || (o_alu_op == NOP)), 1);
    end
  end

  task automatic set_req(input int k, input logic [OW-1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    i_req_op[k*OW +: OW] = op;
    i_req_a[k*DW +: DW]  = a;
    i_req_b[k*DW +: DW]  = b;
    i_req[k]             = 1'b1;
  endtask

  // Counts negedges until ack; expects IDLE, EXEC, READ, DONE (ack on the 4th).
  task automatic wait_ack(input int k, input logic [OW-1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic [3:0] en,
                          input bit early_drop);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge i_clk);
      n++;
      if (n == 2) begin
        check("exec_op", 32'(o_alu_op), 32'(op));
        check("exec_drive", 32'(o_bus_drive), 1);
        check("exec_opnd", 32'(o_bus_opnd), {16'h0, a, b});
        if (early_drop) begin
          #1 i_req[k] = 1'b0;
          i_req_a[k*DW +: DW] = 8'hEE;
        end
      end
      if (n == 3) check("read_flags", 32'(o_alu_read_flags), 1);
      if (o_ack != '0) seen = 1'b1;
    end
    check("ack_latency", n, 4);
    check("ack_onehot", 32'(o_ack), 32'(1) << k);
    check("grant", 32'(o_grant), 32'(1) << k);
    check("result", 32'(o_result), 32'(er));
    check("nzcv", 32'(o_nzcv), 32'(en));
    @(posedge i_clk);
    #1 i_req[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input logic [OW-1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] en,
                        input bit early_drop);
    @(posedge i_clk);
    #1 set_req(k, op, a, b);
    wait_ack(k, op, a, b, er, en, early_drop);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 0);
    check({tag, "_ack"}, 32'(o_ack), 0);
    check({tag, "_result"}, 32'(o_result), 0);
    check({tag, "_nzcv"}, 32'(o_nzcv), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_alu_op"}, 32'(o_alu_op), 32'(NOP));
    check({tag, "_drive"}, 32'(o_bus_drive), 0);
    check({tag, "_opnd"}, 32'(o_bus_opnd), 0);
    check({tag, "_rd"}, 32'(o_alu_read_data | o_alu_read_flags), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ack_seen;
    i_reset  = 1'b1;
    i_req    = '0;
    i_req_op = '0;
    i_req_a  = '0;
    i_req_b  = '0;
    repeat (2) @(posedge i_clk);
    #1 check_all_zero("reset");
    i_reset = 1'b0;
    mon_en  = 1'b1;

    run_op(0, SUM, 8'h05, 8'h03, 8'h08, 4'b0000, 1'b0);
    run_op(0, SUB, 8'h10, 8'h10, 8'h00, 4'b0100, 1'b0);
    run_op(0, SUM, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0);
    run_op(2, NOP, 8'h55, 8'hAA, 8'h00, 4'b0110, 1'b0);
    run_op(1, SUM, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b1);

    // Reset during READ discards the transaction.
    @(posedge i_clk);
    #1 set_req(2, SUM, 8'h11, 8'h22);
    for (int i = 0; i < 8 && !o_alu_read_data; i++) @(negedge i_clk);
    check("reached_read", 32'(o_alu_read_data), 1);
    #1 i_reset = 1'b1;
    #1 check_all_zero("midreset");
    i_req[2] = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    ack_seen = '0;
    repeat (4) begin
      @(negedge i_clk);
      ack_seen = ack_seen | o_ack;
    end
    check("no_ack_after_reset", 32'(ack_seen), 0);
    run_op(3, SUM, 8'h20, 8'h22, 8'h42, 4'b0000, 1'b0);

    // All four contend; each drops after its ack.
    @(posedge i_clk);
    #1;
    set_req(0, SUM, 8'h01, 8'h02);
    set_req(1, SUB, 8'h09, 8'h04);
    set_req(2, SUM, 8'h80, 8'h80);
    set_req(3, SUB, 8'h03, 8'h05);
    wait_ack(0, SUM, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0);
    wait_ack(1, SUB, 8'h09, 8'h04, 8'h05, 4'b0000, 1'b0);
    wait_ack(2, SUM, 8'h80, 8'h80, 8'h00, 4'b0111, 1'b0);
    wait_ack(3, SUB, 8'h03, 8'h05, 8'hFE, 4'b1010, 1'b0);

    @(negedge i_clk);
    check("idle_after", 32'(o_busy), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
